// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game controller: directions, FSM states,
// play-area limits, segment coordinates and overlay pixel codes.
package snake_pkg;

  localparam int COORD_W = 11;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COORD_W:0]   coord_ext_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } seg_t;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_LEFT  = 2'b01,
    DIR_UP    = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_MOVE  = 3'd2,
    ST_CHECK = 3'd3,
    ST_OVER  = 3'd4,
    ST_WON   = 3'd5
  } state_t;

  localparam coord_ext_t WORLD_X_MIN = 12'd212;
  localparam coord_ext_t WORLD_X_MAX = 12'd468;
  localparam coord_ext_t WORLD_Y_MIN = 12'd112;
  localparam coord_ext_t WORLD_Y_MAX = 12'd368;

  localparam logic [1:0] PIX_NONE = 2'b00;
  localparam logic [1:0] PIX_BODY = 2'b01;
  localparam logic [1:0] PIX_HEAD = 2'b11;

  // Opposite directions differ only in bit 0 (right/left, up/down).
  function automatic logic is_opposite(dir_t a, dir_t b);
    return (a ^ b) == 2'b01;
  endfunction

endpackage

// File: rtl/snake_seg_hit.sv
// Combinational per-pixel hit test of the current VGA pixel against the snake's
// head cell and every live segment cell.
module snake_seg_hit
  import snake_pkg::*;
#(
  parameter int CELL    = 8,
  parameter int MAX_LEN = 40
) (
  input  logic [COORD_W-1:0]         pixel_row,
  input  logic [COORD_W-1:0]         pixel_col,
  input  logic [MAX_LEN*COORD_W-1:0] seg_x,
  input  logic [MAX_LEN*COORD_W-1:0] seg_y,
  input  logic [7:0]                 length,
  output logic                       body_hit,
  output logic                       head_hit
);

  // Widened by one bit so lo+CELL-1 cannot wrap near the coordinate limit.
  function automatic logic in_span(coord_t p, coord_t lo);
    coord_ext_t pe;
    coord_ext_t le;
    pe = {1'b0, p};
    le = {1'b0, lo};
    return (pe >= le) && (pe <= le + coord_ext_t'(CELL - 1));
  endfunction

  always_comb begin
    head_hit = in_span(pixel_col, seg_x[COORD_W-1:0]) &&
               in_span(pixel_row, seg_y[COORD_W-1:0]);
    body_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((8'(i) < length) &&
          in_span(pixel_col, seg_x[i*COORD_W +: COORD_W]) &&
          in_span(pixel_row, seg_y[i*COORD_W +: COORD_W]))
        body_hit = 1'b1;
    end
  end

endmodule

// File: rtl/snake_body_ctrl.sv
// Snake movement, collision detection (wall > self > food) and per-pixel overlay
// for the VGA mixer; drives the food generator's eat/length/stop inputs.
module snake_body_ctrl
  import snake_pkg::*;
#(
  parameter int CELL     = 8,
  parameter int MAX_LEN  = 40,
  parameter int INIT_LEN = 3,
  parameter int MOVE_DIV = 4,
  parameter int HEAD_X0  = 340,
  parameter int HEAD_Y0  = 240
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        iTick,
  input  logic        iStart,
  input  logic        iDirValid,
  input  logic [1:0]  iDir,
  input  logic [10:0] iFoodX,
  input  logic [10:0] iFoodY,
  input  logic [10:0] iPixelRow,
  input  logic [10:0] iPixelCol,
  output logic        oEat,
  output logic [7:0]  oSnakeLength,
  output logic        oCtrlOff,
  output logic        oWon,
  output logic [10:0] oHeadX,
  output logic [10:0] oHeadY,
  output logic [1:0]  oSnakePixel
);

  state_t     state, state_nxt;
  seg_t       seg [MAX_LEN];
  dir_t       dir, dir_pend;
  logic [7:0] tick_cnt;
  logic [7:0] len, len_grow;
  logic       eat;
  seg_t       head, head_nxt;
  coord_ext_t hx_lo, hx_hi, hy_lo, hy_hi, fx, fy;
  logic       wall_hit, self_hit, food_hit, move_due, ended;
  logic       body_hit_p0, head_hit_p0;
  logic [MAX_LEN*COORD_W-1:0] seg_x_flat, seg_y_flat;

  function automatic seg_t init_seg(int i);
    int   k;
    seg_t s;
    k   = (i < INIT_LEN) ? i : INIT_LEN - 1;
    s.x = coord_t'(HEAD_X0 - k * CELL);
    s.y = coord_t'(HEAD_Y0);
    return s;
  endfunction

  function automatic logic [7:0] sat_inc_len(logic [7:0] l);
    return (l >= 8'(MAX_LEN)) ? 8'(MAX_LEN) : l + 8'd1;
  endfunction

  function automatic seg_t step_head(seg_t h, dir_t d);
    seg_t n;
    n = h;
    case (d)
      DIR_RIGHT: n.x = h.x + coord_t'(CELL);
      DIR_LEFT:  n.x = h.x - coord_t'(CELL);
      DIR_UP:    n.y = h.y - coord_t'(CELL);
      default:   n.y = h.y + coord_t'(CELL);
    endcase
    return n;
  endfunction

  assign head     = seg[0];
  assign head_nxt = step_head(head, dir_pend);
  assign len_grow = sat_inc_len(len);
  assign move_due = (state == ST_RUN) && iTick && (tick_cnt == 8'(MOVE_DIV - 1));
  assign ended    = (state == ST_OVER) || (state == ST_WON);

  always_comb begin
    hx_lo    = {1'b0, head.x};
    hx_hi    = hx_lo + coord_ext_t'(CELL - 1);
    hy_lo    = {1'b0, head.y};
    hy_hi    = hy_lo + coord_ext_t'(CELL - 1);
    fx       = {1'b0, iFoodX};
    fy       = {1'b0, iFoodY};
    wall_hit = (hx_lo < WORLD_X_MIN) || (hx_hi > WORLD_X_MAX) ||
               (hy_lo < WORLD_Y_MIN) || (hy_hi > WORLD_Y_MAX);
    food_hit = (fx >= hx_lo) && (fx <= hx_hi) && (fy >= hy_lo) && (fy <= hy_hi);
    self_hit = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((8'(i) < len) && (seg[i] == head))
        self_hit = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (iStart) state_nxt = ST_RUN;
      ST_RUN:   if (move_due) state_nxt = ST_MOVE;
      ST_MOVE:  state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (wall_hit || self_hit)
          state_nxt = ST_OVER;
        else if (food_hit && (len_grow == 8'(MAX_LEN)))
          state_nxt = ST_WON;
        else
          state_nxt = ST_RUN;
      end
      ST_OVER:  state_nxt = ST_OVER;
      ST_WON:   state_nxt = ST_WON;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      for (int i = 0; i < MAX_LEN; i++) seg[i] <= init_seg(i);
      dir      <= DIR_RIGHT;
      dir_pend <= DIR_RIGHT;
      tick_cnt <= 8'd0;
      len      <= 8'(INIT_LEN);
      eat      <= 1'b0;
    end else begin
      eat <= 1'b0;
      // A turn is judged against the committed direction, not the pending one.
      if (iDirValid && !ended && !is_opposite(dir_t'(iDir), dir))
        dir_pend <= dir_t'(iDir);
      if (state == ST_RUN && iTick)
        tick_cnt <= move_due ? 8'd0 : tick_cnt + 8'd1;
      if (state == ST_MOVE) begin
        dir <= dir_pend;
        for (int i = MAX_LEN - 1; i > 0; i--) seg[i] <= seg[i-1];
        seg[0] <= head_nxt;
      end
      // The shift already kept the old tail one slot past the length, so growing
      // only needs the length bump.
      if (state == ST_CHECK && !wall_hit && !self_hit && food_hit) begin
        eat <= 1'b1;
        len <= len_grow;
      end
    end
  end

  always_comb begin
    seg_x_flat = '0;
    seg_y_flat = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      seg_x_flat[i*COORD_W +: COORD_W] = seg[i].x;
      seg_y_flat[i*COORD_W +: COORD_W] = seg[i].y;
    end
  end

  snake_seg_hit #(
    .CELL    (CELL),
    .MAX_LEN (MAX_LEN)
  ) u_seg_hit (
    .pixel_row (iPixelRow),
    .pixel_col (iPixelCol),
    .seg_x     (seg_x_flat),
    .seg_y     (seg_y_flat),
    .length    (len),
    .body_hit  (body_hit_p0),
    .head_hit  (head_hit_p0)
  );

  // p0 -> p1: overlay code registered one cycle after the pixel position.
  always_ff @(posedge Clock) begin
    if (!Reset)           oSnakePixel <= PIX_NONE;
    else if (head_hit_p0) oSnakePixel <= PIX_HEAD;
    else if (body_hit_p0) oSnakePixel <= PIX_BODY;
    else                  oSnakePixel <= PIX_NONE;
  end

  assign oEat         = eat;
  assign oSnakeLength = len;
  assign oCtrlOff     = ended;
  assign oWon         = (state == ST_WON);
  assign oHeadX       = seg[0].x;
  assign oHeadY       = seg[0].y;

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Bench for snake_body_ctrl: reset/overlay hand checks, a move table, wall and win
// sequences, and randomized play against a queue-based snake model.
module tb_snake_body_ctrl;

  localparam int CELL     = 8;
  localparam int MAX_LEN  = 40;
  localparam int INIT_LEN = 3;
  localparam int MOVE_DIV = 4;
  localparam int HX0      = 340;
  localparam int HY0      = 240;

  localparam int PH_IDLE  = 0;
  localparam int PH_RUN   = 1;
  localparam int PH_MOVE  = 2;
  localparam int PH_CHECK = 3;
  localparam int PH_OVER  = 4;
  localparam int PH_WON   = 5;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        iTick = 1'b0, iStart = 1'b0, iDirValid = 1'b0;
  logic [1:0]  iDir = 2'd0;
  logic [10:0] iFoodX = 11'd0, iFoodY = 11'd0, iPixelRow = 11'd0, iPixelCol = 11'd0;
  logic        oEat, oCtrlOff, oWon;
  logic [7:0]  oSnakeLength;
  logic [10:0] oHeadX, oHeadY;
  logic [1:0]  oSnakePixel;

  always #5 Clock = ~Clock;

  snake_body_ctrl dut (
    .Clock(Clock), .Reset(Reset), .iTick(iTick), .iStart(iStart),
    .iDirValid(iDirValid), .iDir(iDir), .iFoodX(iFoodX), .iFoodY(iFoodY),
    .iPixelRow(iPixelRow), .iPixelCol(iPixelCol), .oEat(oEat),
    .oSnakeLength(oSnakeLength), .oCtrlOff(oCtrlOff), .oWon(oWon),
    .oHeadX(oHeadX), .oHeadY(oHeadY), .oSnakePixel(oSnakePixel)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: snake as a queue of points, head first
  int m_body[$];
  int m_saved, m_ph, m_dir, m_pend, m_ticks, m_eat, m_pix;
  bit mon_en = 1'b0;

  function automatic int pt(int x, int y); return x * 65536 + y; endfunction
  function automatic int ptx(int p); return p / 65536; endfunction
  function automatic int pty(int p); return p % 65536; endfunction
  function automatic bit in_cell(int col, int row, int p);
    return col >= ptx(p) && col <= ptx(p) + CELL - 1 && row >= pty(p) && row <= pty(p) + CELL - 1;
  endfunction
  function automatic int step_pt(int p, int d);
    int x, y;
    x = ptx(p); y = pty(p);
    case (d)
      0: x = (x + CELL) % 2048;
      1: x = (x - CELL + 2048) % 2048;
      2: y = (y - CELL + 2048) % 2048;
      default: y = (y + CELL) % 2048;
    endcase
    return pt(x, y);
  endfunction

  task automatic model_step();
    int  ph_old, d_old, hx, hy, fx, fy;
    bit  wall, self_c, food, any;
    ph_old = m_ph;
    d_old  = m_dir;
    if (!Reset) begin
      m_body.delete();
      for (int i = 0; i < INIT_LEN; i++) m_body.push_back(pt(HX0 - i * CELL, HY0));
      m_ph = PH_IDLE; m_dir = 0; m_pend = 0; m_ticks = 0; m_eat = 0; m_pix = 0;
      return;
    end
    any = 1'b0;
    foreach (m_body[i]) if (in_cell(int'(iPixelCol), int'(iPixelRow), m_body[i])) any = 1'b1;
    if (in_cell(int'(iPixelCol), int'(iPixelRow), m_body[0])) m_pix = 3;
    else m_pix = any ? 1 : 0;
    m_eat = 0;
    case (m_ph)
      PH_IDLE: if (iStart) m_ph = PH_RUN;
      PH_RUN: if (iTick) begin
        m_ticks++;
        if (m_ticks == MOVE_DIV) begin m_ticks = 0; m_ph = PH_MOVE; end
      end
      PH_MOVE: begin
        m_dir = m_pend;
        m_body.push_front(step_pt(m_body[0], m_dir));
        m_saved = m_body.pop_back();
        m_ph = PH_CHECK;
      end
      PH_CHECK: begin
        hx = ptx(m_body[0]); hy = pty(m_body[0]);
        fx = int'(iFoodX);   fy = int'(iFoodY);
        wall = hx < 212 || hx + CELL - 1 > 468 || hy < 112 || hy + CELL - 1 > 368;
        self_c = 1'b0;
        for (int i = 1; i < m_body.size(); i++) if (m_body[i] == m_body[0]) self_c = 1'b1;
        food = fx >= hx && fx <= hx + CELL - 1 && fy >= hy && fy <= hy + CELL - 1;
        if (wall || self_c) m_ph = PH_OVER;
        else if (food) begin
          m_body.push_back(m_saved);
          m_eat = 1;
          m_ph = (m_body.size() == MAX_LEN) ? PH_WON : PH_RUN;
        end else m_ph = PH_RUN;
      end
      default: ;
    endcase
    if (iDirValid && ph_old != PH_OVER && ph_old != PH_WON && ((int'(iDir) ^ d_old) != 1))
      m_pend = int'(iDir);
  endtask

  always @(posedge Clock) model_step();

  always @(negedge Clock) begin
    if (mon_en && m_body.size() > 0) begin
      check("mdl_head_x", int'(oHeadX), ptx(m_body[0]));
      check("mdl_head_y", int'(oHeadY), pty(m_body[0]));
      check("mdl_length", int'(oSnakeLength), m_body.size());
      check("mdl_eat", int'(oEat), m_eat);
      check("mdl_ctrl_off", int'(oCtrlOff), int'(m_ph == PH_OVER || m_ph == PH_WON));
      check("mdl_won", int'(oWon), int'(m_ph == PH_WON));
      check("mdl_pixel", int'(oSnakePixel), m_pix);
    end
  end

  // ---------------- stimulus helpers
  task automatic do_reset();
    Reset = 1'b0; iTick = 1'b0; iStart = 1'b0; iDirValid = 1'b0;
    @(negedge Clock);
    mon_en = 1'b1;
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  task automatic start_game();
    iStart = 1'b1;
    @(negedge Clock);
    iStart = 1'b0;
  endtask

  task automatic set_dir(input logic [1:0] d);
    iDirValid = 1'b1; iDir = d;
    @(negedge Clock);
    iDirValid = 1'b0;
  endtask

  task automatic pulse_move(output int eats);
    eats = 0;
    for (int t = 0; t < MOVE_DIV; t++) begin
      iTick = 1'b1;
      @(negedge Clock);
      iTick = 1'b0;
      if (oEat) eats++;
      @(negedge Clock);
      if (oEat) eats++;
    end
    repeat (4) begin
      @(negedge Clock);
      if (oEat) eats++;
    end
  endtask

  typedef struct {
    logic       dv;
    logic [1:0] dir;
    int fx, fy;
    int hx, hy, len, eats, off;
  } vec_t;
  vec_t tbl[9];

  typedef struct { int px, py, pix; } pixvec_t;
  pixvec_t ptbl[5];

  int eats, fpt, end_cnt, k, d;

  initial begin
    tbl[0] = '{1'b0, 2'd0, 351, 243, 348, 240, 4, 1, 0};
    tbl[1] = '{1'b0, 2'd0, 356, 240, 356, 240, 5, 1, 0};
    tbl[2] = '{1'b1, 2'd1,   0,   0, 364, 240, 5, 0, 0};
    tbl[3] = '{1'b1, 2'd2,   0,   0, 364, 232, 5, 0, 0};
    tbl[4] = '{1'b1, 2'd3,   0,   0, 364, 224, 5, 0, 0};
    tbl[5] = '{1'b1, 2'd1,   0,   0, 356, 224, 5, 0, 0};
    tbl[6] = '{1'b1, 2'd3,   0,   0, 356, 232, 5, 0, 0};
    tbl[7] = '{1'b1, 2'd0,   0,   0, 364, 232, 5, 0, 1};
    tbl[8] = '{1'b1, 2'd2,   0,   0, 364, 232, 5, 0, 1};
    ptbl[0] = '{243, 342, 3};
    ptbl[1] = '{243, 333, 1};
    ptbl[2] = '{240, 331, 1};
    ptbl[3] = '{243, 320, 0};
    ptbl[4] = '{248, 342, 0};

    // Reset values and idle behaviour
    do_reset();
    @(negedge Clock);
    check("rst_head_x", int'(oHeadX), 340);
    check("rst_head_y", int'(oHeadY), 240);
    check("rst_length", int'(oSnakeLength), 3);
    check("rst_eat", int'(oEat), 0);
    check("rst_ctrl_off", int'(oCtrlOff), 0);
    check("rst_won", int'(oWon), 0);
    check("rst_pixel", int'(oSnakePixel), 0);
    pulse_move(eats);
    check("idle_head_x", int'(oHeadX), 340);
    foreach (ptbl[i]) begin
      iPixelRow = 11'(ptbl[i].px); iPixelCol = 11'(ptbl[i].py);
      @(negedge Clock);
      check("pixel_tbl", int'(oSnakePixel), ptbl[i].pix);
    end

    // Move table: turns, discarded reversals, eating, self collision, freeze
    start_game();
    foreach (tbl[i]) begin
      iFoodX = 11'(tbl[i].fx); iFoodY = 11'(tbl[i].fy);
      if (tbl[i].dv) set_dir(tbl[i].dir);
      pulse_move(eats);
      check("tbl_head_x", int'(oHeadX), tbl[i].hx);
      check("tbl_head_y", int'(oHeadY), tbl[i].hy);
      check("tbl_length", int'(oSnakeLength), tbl[i].len);
      check("tbl_eats", eats, tbl[i].eats);
      check("tbl_ctrl_off", int'(oCtrlOff), tbl[i].off);
      check("tbl_won", int'(oWon), 0);
    end

    // Wall: running right from 340, the move to 468 ends the game
    iFoodX = 11'd0; iFoodY = 11'd0;
    do_reset();
    start_game();
    for (int m = 1; m <= 18; m++) begin
      pulse_move(eats);
      check("wall_head_x", int'(oHeadX), (m <= 16) ? 340 + 8 * m : 468);
      check("wall_ctrl_off", int'(oCtrlOff), int'(m >= 16));
    end
    do_reset();
    @(negedge Clock);
    check("wall_rst_off", int'(oCtrlOff), 0);
    check("wall_rst_x", int'(oHeadX), 340);

    // Win: eat on every move along up/left/down legs until MAX_LEN
    start_game();
    for (int m = 0; m < 37; m++) begin
      d = (m < 14) ? 2 : (m < 24) ? 1 : 3;
      fpt = step_pt(m_body[0], d);
      iFoodX = 11'(ptx(fpt) + 3); iFoodY = 11'(pty(fpt) + 5);
      set_dir(2'(d));
      pulse_move(eats);
      check("win_eats", eats, 1);
    end
    check("win_won", int'(oWon), 1);
    check("win_ctrl_off", int'(oCtrlOff), 1);
    check("win_length", int'(oSnakeLength), MAX_LEN);
    check("win_head_x", int'(oHeadX), 260);
    check("win_head_y", int'(oHeadY), 232);
    pulse_move(eats);
    check("win_frozen_len", int'(oSnakeLength), MAX_LEN);
    check("win_frozen_eat", eats, 0);

    // Randomized play, checked every cycle by the model
    do_reset();
    end_cnt = 0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge Clock);
      end_cnt = (m_ph == PH_OVER || m_ph == PH_WON) ? end_cnt + 1 : 0;
      Reset     = ($urandom_range(0, 499) != 0) && (end_cnt < 40);
      iTick     = ($urandom_range(0, 2) == 0);
      iStart    = ($urandom_range(0, 7) == 0);
      iDirValid = ($urandom_range(0, 5) == 0);
      iDir      = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) begin
        fpt = step_pt(m_body[0], m_pend);
        iFoodX = 11'(ptx(fpt) + $urandom_range(0, 7));
        iFoodY = 11'(pty(fpt) + $urandom_range(0, 7));
      end else begin
        iFoodX = 11'($urandom_range(200, 480));
        iFoodY = 11'($urandom_range(100, 380));
      end
      if ($urandom_range(0, 1) == 0) begin
        k = $urandom_range(0, m_body.size() - 1);
        iPixelCol = 11'(ptx(m_body[k]) + $urandom_range(0, 9) - 1);
        iPixelRow = 11'(pty(m_body[k]) + $urandom_range(0, 9) - 1);
      end else begin
        iPixelCol = 11'($urandom_range(0, 639));
        iPixelRow = 11'($urandom_range(0, 479));
      end
    end
    Reset = 1'b1; iTick = 1'b0; iStart = 1'b0; iDirValid = 1'b0;
    @(negedge Clock);
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
